// File: rtl/complex_mult_stim_gen.sv
// Stimulus/check engine for the complex multiplier: runs N operand transactions over op/res handshakes.
// Define CMPLX_STIM_CHECK_EN to compile in result checking (err_cnt); otherwise err_cnt is tied to 0.
module complex_mult_stim_gen #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          RES_WIDTH   = 2*DATA_WIDTH+2,
  parameter int          SETUP_CYC   = 2,
  parameter int          RES_DLY     = 20,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_trans,
  input  logic                  op_ready,
  input  logic                  res_val,
  input  logic [RES_WIDTH-1:0]  res_re,
  input  logic [RES_WIDTH-1:0]  res_im,
  output logic                  sw_rst,
  output logic                  op_val,
  output logic                  res_ready,
  output logic [DATA_WIDTH-1:0] op_1_re,
  output logic [DATA_WIDTH-1:0] op_1_im,
  output logic [DATA_WIDTH-1:0] op_2_re,
  output logic [DATA_WIDTH-1:0] op_2_im,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           trans_cnt,
  output logic [15:0]           err_cnt
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [1:0]  M_FIXED   = 2'd0;
  localparam logic [1:0]  M_RANDOM  = 2'd1;
  localparam logic [1:0]  M_CORNER  = 2'd2;
  localparam int          CNT_MAX   = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int          CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SRST, S_GEN, S_SETUP, S_OPV, S_RESW, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [15:0]      num_q;
  logic [1:0]       gen_k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      lfsr_q;
  logic             op_hs, res_hs, resw_expire;
  logic [15:0]      trans_inc;
  logic [DATA_WIDTH-1:0] gen_val;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Operand k of the current transaction; INCR wraps at DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] gen_operand(input logic [1:0] m, input logic [1:0] k,
                                                        input logic [15:0] idx, input logic [31:0] s);
    logic [DATA_WIDTH-1:0] v;
    case (m)
      M_FIXED:  v = DATA_WIDTH'(32'd2 + 32'(k));
      M_RANDOM: v = s[DATA_WIDTH-1:0];
      M_CORNER: v = '1;
      default:  v = DATA_WIDTH'(32'(idx) + 32'(k));
    endcase
    return v;
  endfunction

  assign sw_rst    = (state_q == S_SRST);
  assign op_val    = (state_q == S_OPV);
  assign res_ready = (state_q == S_RESW) && (cnt_q >= CNT_W'(RES_DLY));
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

  always_comb begin
    op_hs       = (state_q == S_OPV) && op_ready;
    res_hs      = (state_q == S_RESW) && res_val && res_ready;
    resw_expire = (state_q == S_RESW) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    trans_inc   = sat_inc(trans_cnt);
    gen_val     = gen_operand(mode_q, gen_k_q, trans_cnt, lfsr_q);
    state_d     = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SRST;
      S_SRST:  state_d = (num_q == 16'd0) ? S_FIN : S_GEN;
      S_GEN:   if (gen_k_q == 2'd3) state_d = (SETUP_CYC == 0) ? S_OPV : S_SETUP;
      S_SETUP: if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = S_OPV;
      S_OPV:   if (op_hs) state_d = S_RESW;
      // A result arriving on the expiry edge still counts.
      S_RESW:  begin
        if (res_hs)           state_d = (trans_inc < num_q) ? S_GEN : S_FIN;
        else if (resw_expire) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      num_q     <= '0;
      gen_k_q   <= '0;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      trans_cnt <= '0;
      timeout   <= 1'b0;
      op_1_re   <= '0;
      op_1_im   <= '0;
      op_2_re   <= '0;
      op_2_im   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          mode_q    <= mode;
          num_q     <= num_trans;
          trans_cnt <= '0;
          timeout   <= 1'b0;
        end
        S_SRST: gen_k_q <= '0;
        // The LFSR only steps while generating RANDOM operands, so runs continue the sequence.
        S_GEN: begin
          gen_k_q <= gen_k_q + 2'd1;
          cnt_q   <= '0;
          case (gen_k_q)
            2'd0:    op_1_re <= gen_val;
            2'd1:    op_1_im <= gen_val;
            2'd2:    op_2_re <= gen_val;
            default: op_2_im <= gen_val;
          endcase
          if (mode_q == M_RANDOM) lfsr_q <= lfsr_step(lfsr_q);
        end
        S_SETUP: cnt_q <= cnt_q + CNT_W'(1);
        S_OPV:   cnt_q <= '0;
        S_RESW: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (res_hs)           trans_cnt <= trans_inc;
          else if (resw_expire) timeout   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CMPLX_STIM_CHECK_EN
  logic signed [RES_WIDTH-1:0] exp_re_q, exp_im_q;

  function automatic logic signed [RES_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] v);
    return $signed({{(RES_WIDTH-DATA_WIDTH){1'b0}}, v});
  endfunction

  function automatic logic signed [RES_WIDTH-1:0] cmul_re(input logic [DATA_WIDTH-1:0] a, b, c, d);
    return zext(a) * zext(c) - zext(b) * zext(d);
  endfunction

  function automatic logic signed [RES_WIDTH-1:0] cmul_im(input logic [DATA_WIDTH-1:0] a, b, c, d);
    return zext(a) * zext(d) + zext(b) * zext(c);
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else begin
      if (state_q == S_IDLE && start) err_cnt <= '0;
      if (res_hs && ((res_re != $unsigned(exp_re_q)) || (res_im != $unsigned(exp_im_q))))
        err_cnt <= sat_inc(err_cnt);
    end
  end

  // Operands are stable during OPV, so the expectation is captured on the handshake edge.
  always_ff @(posedge clk) begin
    if (op_hs) begin
      exp_re_q <= cmul_re(op_1_re, op_1_im, op_2_re, op_2_im);
      exp_im_q <= cmul_im(op_1_re, op_1_im, op_2_re, op_2_im);
    end
  end
`else
  logic unused_res;
  assign unused_res = ^{res_re, res_im};
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_complex_mult_stim_gen.sv
// Bench for complex_mult_stim_gen: emulates the multiplier and scoreboards generated operands.
`timescale 1ns/1ps
module tb_complex_mult_stim_gen;
  localparam int          DW          = 8;
  localparam int          RW          = 2*DW+2;
  localparam int          RES_DLY     = 20;
  localparam int          TIMEOUT_CYC = 255;
  localparam logic [31:0] SEED        = 32'hACE1_0001;
  localparam logic [31:0] TAPS        = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   num_trans = 16'd0;
  logic          op_ready = 1'b0;
  logic          res_val = 1'b0;
  logic [RW-1:0] res_re = '0;
  logic [RW-1:0] res_im = '0;
  logic          sw_rst, op_val, res_ready, busy, done, timeout;
  logic [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic [15:0]   trans_cnt, err_cnt;

  complex_mult_stim_gen #(
    .DATA_WIDTH(DW), .RES_WIDTH(RW), .SETUP_CYC(2), .RES_DLY(RES_DLY),
    .TIMEOUT_CYC(TIMEOUT_CYC), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .num_trans(num_trans),
    .op_ready(op_ready), .res_val(res_val), .res_re(res_re), .res_im(res_im),
    .sw_rst(sw_rst), .op_val(op_val), .res_ready(res_ready),
    .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
    .busy(busy), .done(done), .timeout(timeout), .trans_cnt(trans_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] a, b, c, d; } ops_t;
  typedef struct packed { logic [RW-1:0] re, im; } res_t;

  ops_t exp_q[$];
  ops_t got_q[$];
  res_t pend_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] m_lfsr = SEED;

  int  ready_mode = 0;    // 0 always ready, 1 random, 2 never
  bit  res_en = 1'b1;
  bit  corrupt = 1'b0;
  int  cyc = 0;
  bit  op_hs_pend = 1'b0, res_hs_pend = 1'b0, opv_prev = 1'b0;
  ops_t ops_prev;
  int  sw_hi, sw_last, opv_first, done_hi, done_cyc, hs_cyc, rr_first, to_first, hold_err;

  function automatic res_t mult(input ops_t o, input bit bad);
    longint a, b, c, d;
    res_t r;
    a = longint'(o.a); b = longint'(o.b); c = longint'(o.c); d = longint'(o.d);
    r.re = RW'(a*c - b*d);
    r.im = RW'(a*d + b*c - (bad ? 64'sd1 : 64'sd0));
    return r;
  endfunction

  // Multiplier emulator: inputs change on the falling edge; handshakes complete on the next rising edge.
  always @(negedge clk) begin
    ops_t cur;
    cur = {op_1_re, op_1_im, op_2_re, op_2_im};
    cyc++;
    if (!rstn) begin
      op_ready = 1'b0; res_val = 1'b0;
      op_hs_pend = 1'b0; res_hs_pend = 1'b0; opv_prev = 1'b0;
    end else begin
      if (opv_prev && op_val && cur !== ops_prev) hold_err++;
      if (sw_rst) begin sw_hi++; sw_last = cyc; end
      if (op_val && opv_first < 0) opv_first = cyc;
      if (done) begin done_hi++; done_cyc = cyc; end
      if (res_ready && rr_first < 0) rr_first = cyc;
      if (timeout && to_first < 0) to_first = cyc;
      if (res_hs_pend) begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        res_hs_pend = 1'b0;
      end
      res_val = res_en && (pend_q.size() > 0);
      if (res_val) begin res_re = pend_q[0].re; res_im = pend_q[0].im; end
      else begin res_re = '0; res_im = '0; end
      if (res_val && res_ready) res_hs_pend = 1'b1;
      if (op_hs_pend) begin hs_cyc = cyc; op_hs_pend = 1'b0; end
      case (ready_mode)
        0:       op_ready = 1'b1;
        1:       op_ready = ($urandom_range(0, 1) == 1);
        default: op_ready = 1'b0;
      endcase
      if (op_val && op_ready) begin
        got_q.push_back(cur);
        pend_q.push_back(mult(cur, corrupt));
        op_hs_pend = 1'b1;
      end
      opv_prev = op_val;
      ops_prev = cur;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clr_mon();
    sw_hi = 0; sw_last = -1; opv_first = -1; done_hi = 0; done_cyc = -1;
    hs_cyc = -1; rr_first = -1; to_first = -1; hold_err = 0;
    got_q.delete(); pend_q.delete();
  endtask

  // Reference operand model, pushed when a run is requested.
  task automatic push_exp(input int md, input int n);
    ops_t o;
    logic [DW-1:0] v [4];
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 4; k++) begin
        case (md)
          0: v[k] = DW'(2 + k);
          1: begin
            v[k] = m_lfsr[DW-1:0];
            m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? TAPS : 32'h0);
          end
          2: v[k] = '1;
          default: v[k] = DW'(t + k);
        endcase
      end
      o = {v[0], v[1], v[2], v[3]};
      exp_q.push_back(o);
    end
  endtask

  task automatic do_start(input logic [1:0] md, input logic [15:0] n);
    mode = md; num_trans = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({sw_rst, op_val, res_ready, busy, done, timeout} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 000000", {sw_rst, op_val, res_ready, busy, done, timeout});
    end
    n_cmp++;
    if ({trans_cnt, err_cnt} !== 32'h0) begin
      n_bad++; $display("FAIL reset_cnt: got trans=%0d err=%0d expected 0/0", trans_cnt, err_cnt);
    end
    n_cmp++;
    if ({op_1_re, op_1_im, op_2_re, op_2_im} !== '0) begin
      n_bad++; $display("FAIL reset_ops: got %h expected 0", {op_1_re, op_1_im, op_2_re, op_2_im});
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_fixed();
    bit ok;
    ops_t g, e;
    clr_mon(); ready_mode = 0; res_en = 1'b1; corrupt = 1'b0;
    push_exp(0, 1);
    do_start(2'd0, 16'd1);
    wait_done(200, ok);
    step();
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL fixed_done: got done=0 expected 1 within 200 cycles"); end
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL fixed_count: got %0d expected 1", got_q.size()); end
    else if (got_q[0] !== {8'd2, 8'd3, 8'd4, 8'd5}) begin
      n_bad++; $display("FAIL fixed_ops: got %h expected 02030405", got_q[0]);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL fixed_sb: got %h expected %h", g, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (sw_hi != 1) begin n_bad++; $display("FAIL fixed_swrst_len: got %0d cycles expected 1", sw_hi); end
    n_cmp++;
    if (opv_first - sw_last - 1 != 6) begin
      n_bad++; $display("FAIL fixed_opv_delay: got %0d expected 6", opv_first - sw_last - 1);
    end
    n_cmp++;
    if (rr_first - hs_cyc != RES_DLY) begin
      n_bad++; $display("FAIL fixed_res_dly: got %0d expected %0d", rr_first - hs_cyc, RES_DLY);
    end
    n_cmp++;
    if (trans_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      n_bad++; $display("FAIL fixed_cnts: got trans=%0d err=%0d expected 1/0", trans_cnt, err_cnt);
    end
    n_cmp++;
    if (done_hi != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL fixed_done_pulse: got %0d cycles busy=%b expected 1 cycle busy=0", done_hi, busy);
    end
  endtask

  task automatic test_corner();
    bit ok;
    ops_t g, e;
    logic [15:0] exp_err;
`ifdef CMPLX_STIM_CHECK_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif
    clr_mon(); ready_mode = 0; res_en = 1'b1; corrupt = 1'b1;
    push_exp(2, 1);
    do_start(2'd2, 16'd1);
    wait_done(200, ok);
    step();
    corrupt = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL corner_done: got done=0 expected 1"); end
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL corner_count: got %0d expected 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL corner_sb: got %h expected %h", g, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (err_cnt !== exp_err || trans_cnt !== 16'd1) begin
      n_bad++; $display("FAIL corner_err: got err=%0d trans=%0d expected %0d/1", err_cnt, trans_cnt, exp_err);
    end
  endtask

  task automatic test_incr_wrap();
    bit ok;
    ops_t g, e;
    ops_t w255;
    w255 = {8'd255, 8'd0, 8'd1, 8'd2};
    clr_mon(); ready_mode = 1; res_en = 1'b1; corrupt = 1'b0;
    push_exp(3, 300);
    do_start(2'd3, 16'd300);
    wait_done(20000, ok);
    step();
    ready_mode = 0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL incr_done: got done=0 expected 1 within 20000 cycles"); end
    n_cmp++;
    if (got_q.size() < 256) begin n_bad++; $display("FAIL incr_wrap: got %0d transactions expected >=256", got_q.size()); end
    else if (got_q[255] !== w255) begin n_bad++; $display("FAIL incr_wrap: got %h expected %h", got_q[255], w255); end
    n_cmp++;
    if (got_q.size() != 300) begin n_bad++; $display("FAIL incr_count: got %0d expected 300", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL incr_sb: got %h expected %h", g, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (hold_err != 0) begin n_bad++; $display("FAIL incr_hold: got %0d changes expected 0", hold_err); end
    n_cmp++;
    if (trans_cnt !== 16'd300 || err_cnt !== 16'd0) begin
      n_bad++; $display("FAIL incr_cnts: got trans=%0d err=%0d expected 300/0", trans_cnt, err_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    ops_t g, e;
    clr_mon(); ready_mode = 0; res_en = 1'b0; corrupt = 1'b0;
    push_exp(1, 1);
    do_start(2'd1, 16'd3);
    wait_done(600, ok);
    step();
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_done: got done=0 expected 1 within 600 cycles"); end
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL tmo_count: got %0d expected 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL tmo_sb: got %h expected %h", g, e); end
    end
    exp_q.delete();
    n_cmp++;
    if (to_first - hs_cyc != TIMEOUT_CYC) begin
      n_bad++; $display("FAIL tmo_delay: got %0d expected %0d", to_first - hs_cyc, TIMEOUT_CYC);
    end
    n_cmp++;
    if (timeout !== 1'b1 || trans_cnt !== 16'd0 || done_hi != 1) begin
      n_bad++; $display("FAIL tmo_state: got timeout=%b trans=%0d done=%0d expected 1/0/1", timeout, trans_cnt, done_hi);
    end
    res_en = 1'b1;
    clr_mon();
    push_exp(0, 1);
    do_start(2'd0, 16'd1);
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got timeout=%b expected 0", timeout); end
    wait_done(200, ok);
    step();
    n_cmp++;
    if (!ok || trans_cnt !== 16'd1) begin
      n_bad++; $display("FAIL tmo_rerun: got done=%b trans=%0d expected 1/1", ok, trans_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_zero_and_busy();
    bit ok;
    ops_t g, e;
    clr_mon(); ready_mode = 0; res_en = 1'b1;
    do_start(2'd0, 16'd0);
    wait_done(20, ok);
    step();
    n_cmp++;
    if (!ok || sw_hi != 1 || done_cyc - sw_last != 1) begin
      n_bad++; $display("FAIL zero_seq: got done=%b swrst=%0d gap=%0d expected 1/1/1", ok, sw_hi, done_cyc - sw_last);
    end
    n_cmp++;
    if (opv_first != -1 || trans_cnt !== 16'd0) begin
      n_bad++; $display("FAIL zero_noop: got opv_cycle=%0d trans=%0d expected -1/0", opv_first, trans_cnt);
    end
    clr_mon();
    push_exp(0, 2);
    do_start(2'd0, 16'd2);
    repeat (5) step();
    mode = 2'd3; num_trans = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(300, ok);
    step();
    n_cmp++;
    if (!ok || trans_cnt !== 16'd2 || done_hi != 1 || sw_hi != 1) begin
      n_bad++; $display("FAIL busy_ignore: got done=%b trans=%0d dones=%0d swrst=%0d expected 1/2/1/1", ok, trans_cnt, done_hi, sw_hi);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL busy_sb: got %h expected %h", g, e); end
    end
    n_cmp++;
    if (got_q.size() != 0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL busy_count: got %0d/%0d left expected 0/0", got_q.size(), exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_midrun_reset();
    bit ok;
    ops_t g, e;
    clr_mon(); ready_mode = 0; res_en = 1'b1;
    push_exp(1, 2);
    do_start(2'd1, 16'd3);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); if (trans_cnt == 16'd1) begin ok = 1'b1; break; end end
    ready_mode = 2;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin step(); if (op_val) begin ok = 1'b1; break; end end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_reach_opv: got reached=0 expected 1"); end
    rstn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({sw_rst, op_val, res_ready, busy, done, timeout, trans_cnt, err_cnt} !== '0 ||
        {op_1_re, op_1_im, op_2_re, op_2_im} !== '0) begin
      n_bad++; $display("FAIL rst_outputs: got ctrl=%b trans=%0d err=%0d ops=%h expected all 0",
                        {sw_rst, op_val, res_ready, busy, done, timeout}, trans_cnt, err_cnt,
                        {op_1_re, op_1_im, op_2_re, op_2_im});
    end
    rstn = 1'b1;
    n_cmp++;
    if (got_q.size() != 1) begin n_bad++; $display("FAIL rst_pre_count: got %0d expected 1", got_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rst_pre_sb: got %h expected %h", g, e); end
    end
    exp_q.delete();
    m_lfsr = SEED;
    ready_mode = 0;
    step();
    clr_mon();
    push_exp(1, 1);
    do_start(2'd1, 16'd1);
    wait_done(200, ok);
    step();
    n_cmp++;
    if (!ok || got_q.size() != 1) begin
      n_bad++; $display("FAIL rst_rerun: got done=%b count=%0d expected 1/1", ok, got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rst_lfsr_seed: got %h expected %h", g, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_corner();
    test_incr_wrap();
    test_timeout();
    test_zero_and_busy();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
